reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/rob_pkg.sv | 14 +
 rtl/reorder_buffer.sv | 115 +++++++++++
 2 files changed

// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and default sizing.
package rob_pkg;
    localparam int ROB_DEPTH = 8;
    localparam int TAG_W     = $clog2(ROB_DEPTH);
    localparam int DATA_W    = 32;
    localparam int REG_W     = 5;

    typedef struct packed {
        logic             valid;
        logic             done;
        logic [REG_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } rob_entry_t;
endpackage

// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer with out-of-order writeback and flush.
// Define ROB_BYPASS_EN to let a head writeback commit in the same cycle.
module reorder_buffer #(
    parameter int DEPTH    = rob_pkg::ROB_DEPTH,
    parameter int DATA_W   = rob_pkg::DATA_W,
    localparam int TAG_BITS = $clog2(DEPTH)
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  logic [4:0]            alloc_rd,
    output logic                  alloc_ready,
    output logic [TAG_BITS-1:0]   alloc_tag,
    input  logic                  wb_valid,
    input  logic [TAG_BITS-1:0]   wb_tag,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  commit_valid,
    input  logic                  commit_ready,
    output logic [4:0]            commit_rd,
    output logic [DATA_W-1:0]     commit_data,
    output logic [TAG_BITS-1:0]   commit_tag,
    input  logic                  flush,
    output logic [TAG_BITS:0]     count,
    output logic                  full,
    output logic                  empty
);
    import rob_pkg::*;

    logic [DEPTH-1:0]     valid_reg, valid_next;
    logic [DEPTH-1:0]     done_reg, done_next;
    logic [REG_W-1:0]     rd_reg   [DEPTH];
    logic [DATA_W-1:0]    data_reg [DEPTH];
    logic [TAG_BITS-1:0]  head_reg, tail_reg;
    logic [TAG_BITS:0]    count_reg;

    logic alloc_do, commit_do, wb_do;

    assign full        = (count_reg == (TAG_BITS+1)'(DEPTH));
    assign empty       = (count_reg == '0);
    assign count       = count_reg;
    assign alloc_ready = !full;
    assign alloc_tag   = tail_reg;

    assign alloc_do  = alloc_valid && !full;
    // Stale or repeated writebacks fall through here: first result wins.
    assign wb_do     = wb_valid && valid_reg[wb_tag] && !done_reg[wb_tag];
    assign commit_do = commit_valid && commit_ready;

    assign commit_tag = head_reg;
    assign commit_rd  = rd_reg[head_reg];
`ifdef ROB_BYPASS_EN
    assign commit_valid = valid_reg[head_reg] &&
                          (done_reg[head_reg] || (wb_valid && wb_tag == head_reg));
    assign commit_data  = done_reg[head_reg] ? data_reg[head_reg] : wb_data;
`else
    assign commit_valid = valid_reg[head_reg] && done_reg[head_reg];
    assign commit_data  = data_reg[head_reg];
`endif

    // Per-entry next state; alloc and commit never target the same live entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic alloc_hit, commit_hit, wb_hit;
            assign alloc_hit  = alloc_do  && (tail_reg == TAG_BITS'(gi));
            assign commit_hit = commit_do && (head_reg == TAG_BITS'(gi));
            assign wb_hit     = wb_do     && (wb_tag   == TAG_BITS'(gi));

            assign valid_next[gi] = flush      ? 1'b0 :
                                    alloc_hit  ? 1'b1 :
                                    commit_hit ? 1'b0 : valid_reg[gi];
            assign done_next[gi]  = flush      ? 1'b0 :
                                    alloc_hit  ? 1'b0 :
                                    commit_hit ? 1'b0 :
                                    wb_hit     ? 1'b1 : done_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            done_reg  <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            done_reg  <= done_next;
            if (flush) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (alloc_do)
                    tail_reg <= tail_reg + 1'b1;
                if (commit_do)
                    head_reg <= head_reg + 1'b1;
                case ({alloc_do, commit_do})
                    2'b10:   count_reg <= count_reg + 1'b1;
                    2'b01:   count_reg <= count_reg - 1'b1;
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    // Payload storage carries no reset; valid/done decide whether it matters.
    always_ff @(posedge clk1) begin
        if (!flush) begin
            if (alloc_do)
                rd_reg[tail_reg] <= alloc_rd;
            if (wb_do)
                data_reg[wb_tag] <= wb_data;
        end
    end
endmodule
